// File: rtl/onehot_scan_decoder_if.sv
// Bundle of control inputs and strobe outputs for onehot_scan_decoder.
// The master drives select/scan controls; the slave (decoder) returns the strobes.
interface onehot_scan_decoder_if #(
   parameter int SEL_W = 3,
   parameter int DIV_W = 16
);
   localparam int OUT_W = 1 << SEL_W;

   logic             en;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic             load;
   logic [DIV_W-1:0] div;
   logic [SEL_W-1:0] last;
   logic [OUT_W-1:0] out;
   logic [SEL_W-1:0] idx;
   logic             tick;
   logic             wrap;

   modport master (
      output en, mode, sel, load, div, last,
      input  out, idx, tick, wrap
   );

   modport slave (
      input  en, mode, sel, load, div, last,
      output out, idx, tick, wrap
   );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with a DIRECT/SCAN sequencer.
// Define SCAN_BLANK_EN to blank the output for the first cycle of every scan step.
module onehot_scan_decoder #(
   parameter int SEL_W = 3,
   parameter int DIV_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   onehot_scan_decoder_if.slave  bus
);
   localparam int OUT_W = 1 << SEL_W;

   typedef enum logic {ST_DIRECT = 1'b0, ST_SCAN = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [DIV_W-1:0] pre_q, pre_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             blank;
   logic [OUT_W-1:0] dec;

   // one comparator per output line, decoding the next index
   for (genvar g = 0; g < OUT_W; g++) begin : g_line
      assign dec[g] = (idx_d == SEL_W'(g));
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pre_d   = pre_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      blank   = 1'b0;
      if (bus.en) begin
         if (!bus.mode) begin
            state_d = ST_DIRECT;
            idx_d   = bus.sel;
            pre_d   = '0;
         end else begin
            state_d = ST_SCAN;
            if (state_q == ST_DIRECT) begin
               idx_d = '0;
               pre_d = '0;
            end else if (bus.load) begin
               idx_d = bus.sel;
               pre_d = '0;
            end else if (pre_q >= bus.div) begin
               // >= so that lowering div mid-count steps at once instead of
               // running the prescaler all the way round
               pre_d  = '0;
               tick_d = 1'b1;
               if (idx_q >= bus.last) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
`ifdef SCAN_BLANK_EN
            blank = (pre_d == '0) && (bus.div != '0);
`endif
         end
      end
      out_d = (bus.en && !blank) ? dec : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DIRECT;
         idx_q   <= '0;
         pre_q   <= '0;
         out_q   <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         out_q   <= out_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.idx  = idx_q;
   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: DIRECT table plus SCAN sequences.
module tb_onehot_scan_decoder;
   localparam int SEL_W = 3;
   localparam int DIV_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   onehot_scan_decoder_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();
   onehot_scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0] sel;
      logic [7:0] out;
      logic [2:0] idx;
   } dvec_t;
   dvec_t dtab [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string nm, input logic [7:0] eo, input logic [2:0] ei,
                          input logic et, input logic ew);
      chk({nm, ".out"},  32'(bus.out),  32'(eo));
      chk({nm, ".idx"},  32'(bus.idx),  32'(ei));
      chk({nm, ".tick"}, 32'(bus.tick), 32'(et));
      chk({nm, ".wrap"}, 32'(bus.wrap), 32'(ew));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] oh(input int i);
      logic [7:0] r;
      r = 8'h01;
      return r << i;
   endfunction

   // expected output in SCAN: dark on blank cycles only in the blanking build
   function automatic logic [7:0] bo(input int i, input bit blank_cyc);
`ifdef SCAN_BLANK_EN
      return blank_cyc ? 8'h00 : oh(i);
`else
      return blank_cyc ? oh(i) : oh(i);
`endif
   endfunction

   task automatic enter(input logic [15:0] d, input logic [2:0] l);
      bus.mode = 1'b0;
      step();
      bus.div  = d;
      bus.last = l;
      bus.mode = 1'b1;
      step();
      chk_all("enter", bo(0, d != 16'd0), 3'd0, 1'b0, 1'b0);
   endtask

   initial begin
      int ei;
      logic et, ew;

      dtab[0] = '{3'd0, 8'h01, 3'd0};
      dtab[1] = '{3'd1, 8'h02, 3'd1};
      dtab[2] = '{3'd2, 8'h04, 3'd2};
      dtab[3] = '{3'd3, 8'h08, 3'd3};
      dtab[4] = '{3'd4, 8'h10, 3'd4};
      dtab[5] = '{3'd5, 8'h20, 3'd5};
      dtab[6] = '{3'd6, 8'h40, 3'd6};
      dtab[7] = '{3'd7, 8'h80, 3'd7};

      bus.en = 1'b1; bus.mode = 1'b0; bus.sel = 3'd5; bus.load = 1'b0;
      bus.div = 16'd3; bus.last = 3'd5;

      // reset, then DIRECT, then asynchronous reset mid-operation
      repeat (2) step();
      chk_all("rst", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_all("direct_pre", 8'h20, 3'd5, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_all("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         bus.sel = dtab[i].sel;
         step();
         chk_all("direct", dtab[i].out, dtab[i].idx, 1'b0, 1'b0);
      end

      // SCAN div=3 last=5
      enter(16'd3, 3'd5);
      for (int k = 1; k <= 30; k++) begin
         step();
         ei = (k / 4) % 6;
         et = (k % 4 == 0);
         ew = et && (ei == 0);
         chk_all("scan", bo(ei, k % 4 == 0), 3'(ei), et, ew);
      end

      // div=0: step every cycle, never blank
      enter(16'd0, 3'd7);
      for (int k = 1; k <= 16; k++) begin
         step();
         ei = k % 8;
         chk_all("div0", oh(ei), 3'(ei), 1'b1, ei == 0);
      end

      // last=0: idx pinned, wrap on every tick
      enter(16'd1, 3'd0);
      for (int k = 1; k <= 6; k++) begin
         step();
         et = (k % 2 == 0);
         chk_all("last0", bo(0, et), 3'd0, et, et);
      end

      // load coincident with a scheduled step
      enter(16'd2, 3'd7);
      step();
      step();
      chk_all("ld_pre", bo(0, 1'b0), 3'd0, 1'b0, 1'b0);
      bus.load = 1'b1; bus.sel = 3'd6;
      step();
      bus.load = 1'b0;
      chk_all("load", bo(6, 1'b1), 3'd6, 1'b0, 1'b0);
      for (int j = 1; j <= 6; j++) begin
         step();
         ei = (j < 3) ? 6 : (j < 6) ? 7 : 0;
         chk_all("ld_post", bo(ei, j % 3 == 0), 3'(ei), j % 3 == 0, j == 6);
      end

      // enable hold at idx=3, prescaler at 1
      enter(16'd3, 3'd5);
      repeat (13) step();
      chk_all("hold_pre", 8'h08, 3'd3, 1'b0, 1'b0);
      bus.en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk_all("hold", 8'h00, 3'd3, 1'b0, 1'b0);
      end
      bus.en = 1'b1;
      step();
      chk_all("resume1", 8'h08, 3'd3, 1'b0, 1'b0);
      step();
      chk_all("resume2", 8'h08, 3'd3, 1'b0, 1'b0);
      step();
      chk_all("resume3", bo(4, 1'b1), 3'd4, 1'b1, 1'b0);
      step();
      chk_all("resume4", 8'h10, 3'd4, 1'b0, 1'b0);

      // reset mid-scan: outputs drop at once, restart goes through DIRECT
      rst_n = 1'b0;
      #1;
      chk_all("rst_scan", 8'h00, 3'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      step();
      chk_all("rst_reentry", bo(0, 1'b1), 3'd0, 1'b0, 1'b0);

      // load ignored in DIRECT
      bus.mode = 1'b0; bus.sel = 3'd2; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      chk_all("ld_direct", 8'h04, 3'd2, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
